// File: rtl/period_meter.sv
// period_meter
//   Measures a slow, asynchronous square wave in inClk cycles: the length of the
//   last completed high phase, low phase, and their sum, published together with
//   a one-cycle valid strobe at the rising edge that closes a full period.
//   A phase that runs past 2^CNT_W-1 cycles raises the sticky stuck flag and
//   drops the meter back to IDLE until the next edge.
// Ports
//   inClk        system clock, all state on its rising edge
//   reset        synchronous active-high reset
//   sigIn        asynchronous wave under measurement
//   highCycles   last completed high-phase length (CNT_W bits)
//   lowCycles    last completed low-phase length  (CNT_W bits)
//   periodCycles highCycles + lowCycles (CNT_W+1 bits, cannot overflow)
//   valid        one-cycle strobe: the three results were updated this cycle
//   stuck        sticky timeout flag, cleared by the next accepted edge
module period_meter #(
  parameter int CNT_W = 16
) (
  input  logic             inClk,
  input  logic             reset,
  input  logic             sigIn,
  output logic [CNT_W-1:0] highCycles,
  output logic [CNT_W-1:0] lowCycles,
  output logic [CNT_W:0]   periodCycles,
  output logic             valid,
  output logic             stuck
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  // Last counter value a phase may close on; one more idle cycle is a timeout.
  localparam logic [CNT_W-1:0] LAST_CNT = {{(CNT_W-1){1'b1}}, 1'b0};

  state_t           state;
  logic             s1, s2, s3;
  logic [1:0]       flushCnt;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] highReg;
  logic             gotHigh;

  logic             armed;
  logic             rise, fall;
  logic [CNT_W-1:0] phaseLen;

  // Edges are ignored until the synchronizer has been refilled after reset,
  // otherwise a wave that is already high would look like a fresh rise.
  assign armed    = (flushCnt == 2'd3);
  assign rise     = armed &  s2 & ~s3;
  assign fall     = armed & ~s2 &  s3;
  // Counter restarts at 0 on the cycle after an edge, so the distance between
  // edge strobes is counter+1. It never exceeds LAST_CNT, so this cannot wrap.
  assign phaseLen = counter + 1'b1;

  always_ff @(posedge inClk) begin
    if (reset) begin
      state        <= IDLE;
      s1           <= 1'b0;
      s2           <= 1'b0;
      s3           <= 1'b0;
      flushCnt     <= 2'd0;
      counter      <= '0;
      highReg      <= '0;
      gotHigh      <= 1'b0;
      highCycles   <= '0;
      lowCycles    <= '0;
      periodCycles <= '0;
      valid        <= 1'b0;
      stuck        <= 1'b0;
    end else begin
      s1    <= sigIn;
      s2    <= s1;
      s3    <= s2;
      valid <= 1'b0;
      if (!armed) flushCnt <= flushCnt + 2'd1;
      if (rise | fall) stuck <= 1'b0;

      case (state)
        IDLE: begin
          gotHigh <= 1'b0;
          counter <= '0;
          if (rise)      state <= HIGH;
          else if (fall) state <= LOW;
        end
        HIGH: begin
          if (fall) begin
            highReg <= phaseLen;
            gotHigh <= 1'b1;
            counter <= '0;
            state   <= LOW;
          end else if (counter == LAST_CNT) begin
            stuck   <= 1'b1;
            gotHigh <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= phaseLen;
          end
        end
        LOW: begin
          if (rise) begin
            // A low phase entered straight from IDLE has no matching high phase.
            if (gotHigh) begin
              highCycles   <= highReg;
              lowCycles    <= phaseLen;
              periodCycles <= {1'b0, highReg} + {1'b0, phaseLen};
              valid        <= 1'b1;
            end
            counter <= '0;
            state   <= HIGH;
          end else if (counter == LAST_CNT) begin
            stuck   <= 1'b1;
            gotHigh <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end else begin
            counter <= phaseLen;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
